// File: rtl/mips_arb_pkg.sv
// mips_arb_pkg: shared types and constants for the unified-memory arbiter
package mips_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    localparam logic [31:0] ERR_RDATA = 32'h0;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/mips_mem_arbiter_wdt.sv
// arb_wdt_counter: 8-bit watchdog; clr zeroes, en counts, tc flags count == LIMIT-1
//   clk, rst : clock, sync active-high reset
//   clr, en  : clear (priority over en) / count enable
//   tc       : terminal count reached
module arb_wdt_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [7:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 8'd1;
    end
    assign tc = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between fetch and data ports
//   if_*  : fetch requester (read-only), if_ack/if_rdata registered, if_stall combinational
//   d_*   : data requester (read/write), d_ack/d_rdata registered, d_stall combinational
//   err   : pulses with the ack of an access that timed out (rdata returned as 0)
//   mem_* : request/ack handshake to the memory; mem_req held until mem_ack
//   MEM_ARB_STARVE_GUARD_EN : when defined, fetch is forced after STARVE_LIMIT
//                             consecutive contested data wins
module mips_mem_arbiter
    import mips_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);
    state_t         state;
    owner_t         owner;
    logic           busy;
    logic           wdt_tc;
    logic           grant_d;
    logic [DW-1:0]  resp_data;

    assign busy      = state == BUSY_I || state == BUSY_D;
    assign owner     = state == BUSY_D ? OWN_D : OWN_I;
    assign resp_data = mem_ack ? mem_rdata : DW'(ERR_RDATA);
    assign if_stall  = if_req & ~if_ack;
    assign d_stall   = d_req & ~d_ack;

    // Counts BUSY cycles without an ack; starts from zero at every grant.
    arb_wdt_counter #(.LIMIT(TIMEOUT)) u_wdt (
        .clk (clk),
        .rst (rst),
        .clr (!busy),
        .en  (busy && !mem_ack),
        .tc  (wdt_tc)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;
    // Data loses only when fetch is also waiting and has been passed over STARVE_LIMIT times.
    assign grant_d = d_req && !(if_req && starve_cnt == 8'(STARVE_LIMIT));
    always_ff @(posedge clk) begin
        if (rst) starve_cnt <= '0;
        else if (state == IDLE && (d_req || if_req))
            starve_cnt <= !grant_d ? '0 : if_req ? starve_cnt + 8'd1 : starve_cnt;
    end
`else
    assign grant_d = d_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: if (d_req || if_req) begin
                    state     <= grant_d ? BUSY_D : BUSY_I;
                    mem_req   <= 1'b1;
                    mem_we    <= grant_d && d_we;
                    mem_addr  <= grant_d ? d_addr : if_addr;
                    mem_wdata <= grant_d ? d_wdata : '0;
                end
                // Acks are registered here so they are visible during the RESP cycle.
                BUSY_I, BUSY_D: if (mem_ack || wdt_tc) begin
                    state   <= RESP;
                    mem_req <= 1'b0;
                    err     <= !mem_ack;
                    if (owner == OWN_I) begin
                        if_ack   <= 1'b1;
                        if_rdata <= resp_data;
                    end else begin
                        d_ack <= 1'b1;
                        if (!mem_we) d_rdata <= resp_data;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: scoreboard bench for mips_mem_arbiter (TIMEOUT=8, STARVE_LIMIT=2)
module tb_mips_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_ack, if_stall, d_ack, d_stall, err, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        mem_auto = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_d_rdata = '0;

    mips_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h2008_0045;
    endfunction

    assign mem_rdata = mem_ack ? mem_f(mem_addr) : 32'hDEAD_BEEF;

    // Advance one cycle; the auto memory acks one cycle after it first sees mem_req.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (mem_auto) mem_ack = mem_req && prev_req && !mem_ack;
        prev_req = mem_req;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if ({mem_req, mem_we, if_ack, d_ack, err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, if_ack, d_ack, err});
        end
        n_cmp++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_mem_bus: got %h %h expected 0 0", mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            n_bad++; $display("FAIL reset_rdata: got %h %h expected 0 0", if_rdata, d_rdata);
        end
        n_cmp++;
        if ({if_stall, d_stall} !== 2'b00) begin
            n_bad++; $display("FAIL reset_stall: got %b expected 00", {if_stall, d_stall});
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_fetch();
        mem_auto = 1'b1;
        if_req = 1'b1;
        if_addr = 32'h40;
        sb.push_back(exp_t'{1'b0, 1'b0, 32'h2008_0005});
        #1;
        n_cmp++;
        if (if_stall !== 1'b1) begin
            n_bad++; $display("FAIL fetch_stall_c0: got %b expected 1", if_stall);
        end
        for (int t = 1; t <= 2; t++) begin
            cycle();
            n_cmp++;
            if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin
                n_bad++; $display("FAIL fetch_mem_c%0d: got req=%b we=%b addr=%h expected 1 0 40", t, mem_req, mem_we, mem_addr);
            end
            n_cmp++;
            if ({if_stall, if_ack} !== 2'b10) begin
                n_bad++; $display("FAIL fetch_stall_c%0d: got stall=%b ack=%b expected 1 0", t, if_stall, if_ack);
            end
        end
        cycle();
        e = sb.pop_front();
        n_cmp++;
        if ({if_ack, d_ack} !== 2'b10) begin
            n_bad++; $display("FAIL fetch_ack_c3: got if_ack=%b d_ack=%b expected 1 0", if_ack, d_ack);
        end
        n_cmp++;
        if (if_rdata !== e.rdata || err !== e.err) begin
            n_bad++; $display("FAIL fetch_data: got %h err=%b expected %h err=%b", if_rdata, err, e.rdata, e.err);
        end
        n_cmp++;
        if (if_stall !== 1'b0) begin
            n_bad++; $display("FAIL fetch_stall_c3: got %b expected 0", if_stall);
        end
        if_req = 1'b0;
        cycle();
        n_cmp++;
        if (if_ack !== 1'b0 || if_rdata !== 32'h2008_0005) begin
            n_bad++; $display("FAIL fetch_hold: got ack=%b rdata=%h expected 0 20080005", if_ack, if_rdata);
        end
    endtask

    task automatic test_both();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        if_req = 1'b1; if_addr = 32'h44;
        sb.push_back(exp_t'{1'b1, 1'b0, mem_f(32'h100)});
        sb.push_back(exp_t'{1'b0, 1'b0, mem_f(32'h44)});
        exp_d_rdata = mem_f(32'h100);
        for (int t = 1; t <= 12 && sb.size() > 0; t++) begin
            cycle();
            if (if_ack || d_ack) begin
                e = sb.pop_front();
                n_cmp++;
                if (d_ack !== e.is_d || if_ack !== !e.is_d) begin
                    n_bad++; $display("FAIL both_owner: got d_ack=%b if_ack=%b expected d_ack=%b", d_ack, if_ack, e.is_d);
                end
                n_cmp++;
                if ((e.is_d ? d_rdata : if_rdata) !== e.rdata || err !== e.err) begin
                    n_bad++; $display("FAIL both_data: got %h err=%b expected %h err=%b", e.is_d ? d_rdata : if_rdata, err, e.rdata, e.err);
                end
                n_cmp++;
                if (t != (e.is_d ? 3 : 7)) begin
                    n_bad++; $display("FAIL both_latency: got c%0d expected c%0d", t, e.is_d ? 3 : 7);
                end
                if (d_ack) d_req = 1'b0;
                if (if_ack) if_req = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL both_missing_ack: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        if_req = 1'b0; d_req = 1'b0;
        cycle();
    endtask

    task automatic test_write();
        int seen = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hA5A5_A5A5;
        sb.push_back(exp_t'{1'b1, 1'b0, exp_d_rdata});
        for (int t = 1; t <= 10 && sb.size() > 0; t++) begin
            cycle();
            if (mem_req) begin
                seen++;
                n_cmp++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h200, 32'hA5A5_A5A5}) begin
                    n_bad++; $display("FAIL write_bus: got we=%b addr=%h wdata=%h expected 1 200 a5a5a5a5", mem_we, mem_addr, mem_wdata);
                end
            end
            if (if_ack || d_ack) begin
                e = sb.pop_front();
                n_cmp++;
                if ({d_ack, if_ack, err} !== {e.is_d, 1'b0, e.err} || d_rdata !== e.rdata) begin
                    n_bad++; $display("FAIL write_ack: got d_ack=%b if_ack=%b err=%b d_rdata=%h expected 1 0 0 %h", d_ack, if_ack, err, d_rdata, e.rdata);
                end
                d_req = 1'b0; d_we = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0 || seen != 2) begin
            n_bad++; $display("FAIL write_handshake: got pending=%0d req_cycles=%0d expected 0 2", sb.size(), seen);
            sb.delete();
        end
        d_req = 1'b0;
        cycle();
    endtask

    task automatic test_timeout();
        mem_auto = 1'b0;
        mem_ack = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        sb.push_back(exp_t'{1'b0, 1'b1, 32'h0});
        for (int t = 1; t <= 14 && sb.size() > 0; t++) begin
            cycle();
            if (t <= 8) begin
                n_cmp++;
                if ({mem_req, if_ack} !== 2'b10) begin
                    n_bad++; $display("FAIL timeout_busy_c%0d: got req=%b ack=%b expected 1 0", t, mem_req, if_ack);
                end
            end
            if (if_ack || d_ack) begin
                e = sb.pop_front();
                n_cmp++;
                if (t != 9 || d_ack !== 1'b0) begin
                    n_bad++; $display("FAIL timeout_latency: got c%0d d_ack=%b expected c9 0", t, d_ack);
                end
                n_cmp++;
                if (err !== e.err || if_rdata !== e.rdata || mem_req !== 1'b0) begin
                    n_bad++; $display("FAIL timeout_resp: got err=%b rdata=%h req=%b expected 1 0 0", err, if_rdata, mem_req);
                end
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL timeout_no_ack: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        if_req = 1'b0;
        cycle();
        mem_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        mem_auto = 1'b0;
        mem_ack = 1'b0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        cycle();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            n_bad++; $display("FAIL rstmid_busy: got req=%b addr=%h expected 1 300", mem_req, mem_addr);
        end
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        d_req = 1'b0;
        exp_d_rdata = '0;
        n_cmp++;
        if ({mem_req, d_ack, if_ack} !== 3'b000 || mem_addr !== 32'h0 || d_rdata !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_abort: got req=%b d_ack=%b if_ack=%b addr=%h d_rdata=%h expected 0 0 0 0 0", mem_req, d_ack, if_ack, mem_addr, d_rdata);
        end
        mem_ack = 1'b1;
        cycle();
        mem_ack = 1'b0;
        for (int t = 0; t < 4; t++) begin
            n_cmp++;
            if ({mem_req, d_ack, if_ack, err} !== 4'b0) begin
                n_bad++; $display("FAIL rstmid_late_ack: got req=%b d_ack=%b if_ack=%b err=%b expected 0 0 0 0", mem_req, d_ack, if_ack, err);
            end
            cycle();
        end
        mem_auto = 1'b1;
        if_req = 1'b1; if_addr = 32'h48;
        sb.push_back(exp_t'{1'b0, 1'b0, mem_f(32'h48)});
        for (int t = 1; t <= 10 && sb.size() > 0; t++) begin
            cycle();
            if (if_ack || d_ack) begin
                e = sb.pop_front();
                n_cmp++;
                if (t != 3 || d_ack !== 1'b0 || if_rdata !== e.rdata || err !== e.err) begin
                    n_bad++; $display("FAIL rstmid_recover: got c%0d d_ack=%b rdata=%h err=%b expected c3 0 %h 0", t, d_ack, if_rdata, err, e.rdata);
                end
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL rstmid_no_ack: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        if_req = 1'b0;
        cycle();
    endtask

    task automatic test_starve();
        logic is_d;
        int   k = 0;
        mem_auto = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
        if_req = 1'b1; if_addr = 32'h600;
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            is_d = (i % 3) != 2;
`else
            is_d = 1'b1;
`endif
            sb.push_back(exp_t'{is_d, 1'b0, mem_f(is_d ? 32'h500 : 32'h600)});
        end
        for (int t = 1; t <= 40 && sb.size() > 0; t++) begin
            cycle();
            if (if_ack || d_ack) begin
                e = sb.pop_front();
                n_cmp++;
                if (d_ack !== e.is_d || if_ack !== !e.is_d) begin
                    n_bad++; $display("FAIL starve_order_%0d: got d_ack=%b if_ack=%b expected d_ack=%b", k, d_ack, if_ack, e.is_d);
                end
                n_cmp++;
                if ((e.is_d ? d_rdata : if_rdata) !== e.rdata) begin
                    n_bad++; $display("FAIL starve_data_%0d: got %h expected %h", k, e.is_d ? d_rdata : if_rdata, e.rdata);
                end
                k++;
                if (sb.size() == 0) begin
                    d_req = 1'b0;
                    if_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++; $display("FAIL starve_missing: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        d_req = 1'b0; if_req = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_both();
        test_write();
        test_timeout();
        test_reset_mid();
        test_starve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no summary expected finish");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Arbitrates one single-port unified memory between the instruction-fetch port (read-only) and the data-memory port (read/write) of the 5-stage pipeline.
- Sequences each access through a request/ack handshake with the memory.
- Generates stall indications back to the fetch and memory stages.
- Provides a watchdog so a missing memory ack cannot hang the pipeline.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum number of BUSY cycles waiting for mem_ack before the access is aborted (legal range 2..255).
- STARVE_LIMIT, 4, consecutive data wins allowed before fetch is forced (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high, clk domain.
- if_req  in  1  fetch request.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  DW  fetched instruction; valid while if_ack=1, then held.
- if_stall  out  1  if_req & ~if_ack (combinational).
- d_req  in  1  data request.
- d_we  in  1  1 = write.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DW  load data; valid while d_ack=1, then held.
- d_stall  out  1  d_req & ~d_ack (combinational).
- err  out  1  pulses together with if_ack/d_ack when the access timed out.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid when mem_ack=1.
- mem_ack  in  1  memory completion, single cycle.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP. All outputs registered except if_stall/d_stall.
- Reset (sync, any state, including mid-access) forces:
  - state=IDLE;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - if_ack=0, d_ack=0, err=0;
  - if_rdata=0, d_rdata=0;
  - timeout and starve counters cleared.
  - The outstanding access is dropped and no ack is issued.
- IDLE: if d_req, go to BUSY_D; else if if_req, go to BUSY_I; else stay. On grant, latch the selected address, we and wdata into mem_addr/mem_we/mem_wdata, and set mem_req=1 next cycle. Fetch grants force mem_we=0.
- BUSY_x:
  - mem_req=1 and mem_* stable.
  - mem_ack=1: capture mem_rdata (reads only); mem_req=0 and state=RESP next cycle.
  - No ack: the timeout counter increments. If the counter reaches TIMEOUT-1 with no ack, mem_req drops, state goes to RESP with err set, and the returned rdata is 0.
- RESP (exactly one cycle):
  - Pulse the owner's ack, plus err if flagged.
  - The owner's rdata register updates on reads. d_rdata is unchanged on writes.
  - Next state is IDLE.
  - Requesters must update or drop req in the cycle after ack. req seen in IDLE is a new request.
- Latency: grant decision in c0, mem_req in c1, mem_ack in cN, ack in cN+1, IDLE in cN+2. One access in flight; no pipelining.
- mem_ack is ignored in IDLE and RESP.
- Requester inputs are sampled only in IDLE, so changes during BUSY have no effect.
- Simultaneous if_req and d_req: data wins (the older instruction is in the memory stage).

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined: a counter increments on each IDLE decision where both requests are present and data wins. When the counter equals STARVE_LIMIT, fetch wins that decision and the counter clears. The counter also clears whenever fetch is granted.
- Undefined: strict data priority; no counter logic.

Decomposition:
- Package mips_arb_pkg:
  - state enum (IDLE, BUSY_I, BUSY_D, RESP);
  - owner encoding (OWN_I, OWN_D);
  - constant ERR_RDATA = 0;
  - default TIMEOUT and STARVE_LIMIT constants.
- One sub-module, arb_wdt_counter: clear/enable/terminal-count watchdog, 8-bit.

Test Plan:
- Fetch only: if_req, if_addr=0x40 at c0; mem_ack, mem_rdata=0x20080005 at c2 -> mem_req=1 and mem_addr=0x40 at c1..c2; if_ack=1 and if_rdata=0x20080005 at c3; if_stall=1 during c0..c2.
- Both requests at c0 (d_addr=0x100 read, if_addr=0x44), memory acks after 1 cycle each -> data served first (d_ack at c3), fetch granted in IDLE at c4, if_ack at c7.
- Write: d_we=1, d_addr=0x200, d_wdata=0xA5A5A5A5 -> mem_we=1 with those values while mem_req=1; d_ack pulses; d_rdata keeps its prior value; err=0.
- Timeout with TIMEOUT=8: fetch granted at c0, mem_ack never asserted -> mem_req=1 for c1..c8; at c9 if_ack=1, err=1, if_rdata=0; IDLE at c10.
- Reset mid-access: rst=1 during BUSY_D -> next cycle mem_req=0 and state IDLE; no d_ack; a late mem_ack is ignored.
- Starvation, STARVE_LIMIT=2, both reqs permanently high, 1-cycle memory:
  - Macro defined: grant order D, D, I, D, D, I.
  - Macro undefined: D only.
